// File: rtl/wb_stage.sv
// wb_stage: MEM->WB pipeline register, load extraction, writeback mux and WB->ID bypass.
// Defining WB_INSTRET_EN adds the 64-bit retired-instruction counter o_instret.
module wb_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        MEM_insn_vld,
  input  logic        MEM_rd_wren,
  input  logic [4:0]  MEM_rd_addr,
  input  logic [1:0]  MEM_wb_sel,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_alu_data,
  input  logic [31:0] MEM_ld_data,
  input  logic [31:0] MEM_pc,
  input  logic [1:0]  MEM_addr_lsb,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [4:0]  ID_rs1_addr,
  input  logic [4:0]  ID_rs2_addr,
  input  logic        id_is_rs1,
  input  logic        id_is_rs2,
  output logic        WB_rd_wren,
  output logic [4:0]  WB_rd_addr,
  output logic [31:0] WB_wb_data,
  output logic        ID_forward_rs1,
  output logic        ID_forward_rs2,
  output logic        WB_insn_vld
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] o_instret
`endif
);

  logic        valid_q, valid_d;
  logic        rd_wren_q, rd_wren_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] ld_q, ld_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  lsb_q, lsb_d;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic [31:0] wb_mux;
  logic        wren_int;

  // Flush only kills valid; the payload fields keep their held contents.
  always_comb begin
    valid_d   = valid_q;
    rd_wren_d = rd_wren_q;
    rd_addr_d = rd_addr_q;
    wb_sel_d  = wb_sel_q;
    funct3_d  = funct3_q;
    alu_d     = alu_q;
    ld_d      = ld_q;
    pc_d      = pc_q;
    lsb_d     = lsb_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (!i_stall) begin
      valid_d   = MEM_insn_vld;
      rd_wren_d = MEM_rd_wren;
      rd_addr_d = MEM_rd_addr;
      wb_sel_d  = MEM_wb_sel;
      funct3_d  = MEM_funct3;
      alu_d     = MEM_alu_data;
      ld_d      = MEM_ld_data;
      pc_d      = MEM_pc;
      lsb_d     = MEM_addr_lsb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      rd_wren_q <= 1'b0;
      rd_addr_q <= 5'd0;
      wb_sel_q  <= 2'd0;
      funct3_q  <= 3'd0;
      alu_q     <= 32'd0;
      ld_q      <= 32'd0;
      pc_q      <= 32'd0;
      lsb_q     <= 2'd0;
    end else begin
      valid_q   <= valid_d;
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      wb_sel_q  <= wb_sel_d;
      funct3_q  <= funct3_d;
      alu_q     <= alu_d;
      ld_q      <= ld_d;
      pc_q      <= pc_d;
      lsb_q     <= lsb_d;
    end
  end

  // Halfword select uses lsb[1] only, so a misaligned half silently aligns down.
  always_comb begin
    byte_sel = ld_q[7:0];
    case (lsb_q)
      2'b00: byte_sel = ld_q[7:0];
      2'b01: byte_sel = ld_q[15:8];
      2'b10: byte_sel = ld_q[23:16];
      2'b11: byte_sel = ld_q[31:24];
      default: byte_sel = ld_q[7:0];
    endcase
    half_sel = lsb_q[1] ? ld_q[31:16] : ld_q[15:0];
    ld_ext = ld_q;
    case (funct3_q)
      3'b000: ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001: ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b100: ld_ext = {24'd0, byte_sel};
      3'b101: ld_ext = {16'd0, half_sel};
      default: ld_ext = ld_q;
    endcase
    wb_mux = alu_q;
    case (wb_sel_q)
      2'b01: wb_mux = ld_ext;
      2'b10: wb_mux = pc_q + 32'd4;
      default: wb_mux = alu_q;
    endcase
  end

  // Outputs are forced low while reset is asserted, not just after the reset edge.
  assign wren_int       = !i_rst && valid_q && rd_wren_q && (rd_addr_q != 5'd0);
  assign WB_rd_wren     = wren_int;
  assign WB_rd_addr     = rd_addr_q;
  assign WB_wb_data     = i_rst ? 32'd0 : wb_mux;
  assign WB_insn_vld    = !i_rst && valid_q;
  assign ID_forward_rs1 = wren_int && id_is_rs1 && (rd_addr_q == ID_rs1_addr);
  assign ID_forward_rs2 = wren_int && id_is_rs2 && (rd_addr_q == ID_rs2_addr);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (MEM_insn_vld && !i_stall && !i_flush) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) instret_q <= 64'd0;
    else       instret_q <= instret_d;
  end

  assign o_instret = instret_q;
`endif

endmodule
